// File: rtl/axis_ecg_sample_source.sv
// AXI-Stream source: converts strobed ADC codes to signed words and buffers them in a FWFT FIFO.
// Optional build macro AXIS_SRC_DROP_CNT_EN adds a saturating dropped-sample counter output o_drop_cnt.
`timescale 1ns/1ps

module axis_ecg_sample_source #(
    parameter int DATA_W     = 12,
    parameter int AXIS_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int OFFSET_BIN = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_sample_valid,
    input  logic [DATA_W-1:0]             i_sample,
    input  logic                          i_ovf_clr,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tvalid,
    output logic [AXIS_W-1:0]             m_axis_tdata,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow
`ifdef AXIS_SRC_DROP_CNT_EN
    ,
    output logic [15:0]                   o_drop_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    logic [AXIS_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] conv_x;
    logic [AXIS_W-1:0] conv_word;
    logic              full;
    logic              rd_fire;
    logic              wr_fire;
    logic              drop;

    // A full FIFO still accepts a write when the head word leaves on the same edge.
    always_comb begin
        conv_x    = (OFFSET_BIN != 0) ? {~i_sample[DATA_W-1], i_sample[DATA_W-2:0]} : i_sample;
        conv_word = {{(AXIS_W-DATA_W){conv_x[DATA_W-1]}}, conv_x};

        full    = (level_q == FULL_LVL);
        rd_fire = m_axis_tvalid & m_axis_tready;
        wr_fire = i_sample_valid & (~full | rd_fire);
        drop    = i_sample_valid & full & ~rd_fire;

        wr_ptr_d = wr_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        case ({wr_fire, rd_fire})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            if (wr_fire) begin
                mem_q[wr_ptr_q] <= conv_word;
            end
        end
    end

    assign m_axis_tvalid = (level_q != '0);
    assign m_axis_tdata  = mem_q[rd_ptr_q];
    assign o_fifo_level  = level_q;
    assign o_overflow    = ovf_q;

`ifdef AXIS_SRC_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // A clear coinciding with a drop restarts the count at one rather than zero.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (i_ovf_clr) begin
            drop_cnt_d = {15'd0, drop};
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_axis_ecg_sample_source.sv
// Self-checking bench for axis_ecg_sample_source: a queue-based reference model compared every cycle,
// plus directed literal checks (reset, conversion, full/drop, simultaneous read+write, random backpressure).
`timescale 1ns/1ps

module tb_axis_ecg_sample_source;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        sampleValid;
    logic [11:0] sample;
    logic        ovfClr;
    logic        tready;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  fifoLevel;
    logic        overflow;
`ifdef AXIS_SRC_DROP_CNT_EN
    logic [15:0] dropCnt;
`endif

    int testsRun    = 0;
    int testsFailed = 0;
    int rxCount     = 0;
    logic [31:0] lastRxData = '0;

    axis_ecg_sample_source #(
        .DATA_W(12), .AXIS_W(32), .FIFO_DEPTH(DEPTH), .OFFSET_BIN(1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_sample_valid (sampleValid),
        .i_sample       (sample),
        .i_ovf_clr      (ovfClr),
        .m_axis_tready  (tready),
        .m_axis_tvalid  (tvalid),
        .m_axis_tdata   (tdata),
        .o_fifo_level   (fifoLevel),
        .o_overflow     (overflow)
`ifdef AXIS_SRC_DROP_CNT_EN
        ,
        .o_drop_cnt     (dropCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offset-binary code to signed value: subtract mid-scale, then keep 32 bits.
    function automatic logic [31:0] convSample(input logic [11:0] code);
        int v;
        v = int'(code) - 2048;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a queue of words plus a sticky drop flag, advanced on every rising edge.
    logic [31:0] expQ [$];
    logic        expOvf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            expQ.delete();
            expOvf = 1'b0;
        end else begin
            logic doRead;
            logic doDrop;
            doRead = (expQ.size() != 0) && tready;
            doDrop = sampleValid && (expQ.size() == DEPTH) && !doRead;
            if (doRead) void'(expQ.pop_front());
            if (sampleValid && !doDrop) expQ.push_back(convSample(sample));
            if (doDrop) expOvf = 1'b1;
            else if (ovfClr) expOvf = 1'b0;
        end
    end

    // Compare process: outputs against the model mid-cycle, plus AXIS hold-while-stalled rule.
    logic        prevValid = 1'b0;
    logic        prevReady = 1'b0;
    logic [31:0] prevData  = '0;

    always @(negedge clk) begin
        checkOutput("cmp_tvalid", {31'd0, tvalid}, {31'd0, expQ.size() != 0});
        checkOutput("cmp_level", {28'd0, fifoLevel}, 32'(expQ.size()));
        checkOutput("cmp_overflow", {31'd0, overflow}, {31'd0, expOvf});
        if (expQ.size() != 0) begin
            checkOutput("cmp_tdata", tdata, expQ[0]);
        end
        if (rst) begin
            prevValid = 1'b0;
        end else begin
            if (prevValid && !prevReady) begin
                checkOutput("hold_tvalid", {31'd0, tvalid}, 32'd1);
                checkOutput("hold_tdata", tdata, prevData);
            end
            if (tvalid && tready) begin
                rxCount++;
                lastRxData = tdata;
            end
            prevValid = tvalid;
            prevReady = tready;
            prevData  = tdata;
        end
    end

    task automatic applyStimulus(input logic v, input logic [11:0] s, input logic rdy, input logic clr);
        sampleValid = v;
        sample      = s;
        tready      = rdy;
        ovfClr      = clr;
        @(posedge clk);
        #1;
        sampleValid = 1'b0;
        ovfClr      = 1'b0;
    endtask

    task automatic drainFifo();
        for (int n = 0; n < 4 * DEPTH && expQ.size() != 0; n++) begin
            applyStimulus(1'b0, 12'h000, 1'b1, 1'b0);
        end
        checkOutput("drain_tvalid", {31'd0, tvalid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rxStart;
        logic rdy;

        rst = 1'b1;
        sampleValid = 1'b0;
        sample = '0;
        tready = 1'b0;
        ovfClr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tvalid", {31'd0, tvalid}, 32'd0);
        checkOutput("reset_tdata", tdata, 32'h0000_0000);
        checkOutput("reset_level", {28'd0, fifoLevel}, 32'd0);
        checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;

        // Conversion and one-cycle latency.
        applyStimulus(1'b1, 12'h800, 1'b1, 1'b0);
        checkOutput("t1_tvalid", {31'd0, tvalid}, 32'd1);
        checkOutput("t1_mid_scale", tdata, 32'h0000_0000);
        applyStimulus(1'b1, 12'h000, 1'b1, 1'b0);
        checkOutput("t1_neg_full_scale", tdata, 32'hFFFF_F800);
        checkOutput("t1_level", {28'd0, fifoLevel}, 32'd1);
        applyStimulus(1'b0, 12'h000, 1'b1, 1'b0);
        checkOutput("t1_empty", {31'd0, tvalid}, 32'd0);

        // Fill under backpressure, then one dropped sample.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 12'(i), 1'b0, 1'b0);
        end
        checkOutput("t2_level_full", {28'd0, fifoLevel}, 32'd8);
        checkOutput("t2_no_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("t2_head", tdata, 32'hFFFF_F801);
        applyStimulus(1'b1, 12'd9, 1'b0, 1'b0);
        checkOutput("t2_overflow_set", {31'd0, overflow}, 32'd1);
        checkOutput("t2_level_kept", {28'd0, fifoLevel}, 32'd8);
        rxStart = rxCount;
        drainFifo();
        checkOutput("t2_rx_count", 32'(rxCount - rxStart), 32'd8);
        checkOutput("t2_last_word", lastRxData, 32'hFFFF_F808);
        applyStimulus(1'b0, 12'h000, 1'b1, 1'b1);
        checkOutput("t2_overflow_clr", {31'd0, overflow}, 32'd0);

        // Full FIFO with simultaneous read and write.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 12'h010 + 12'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 12'h099, 1'b1, 1'b0);
        checkOutput("t3_level", {28'd0, fifoLevel}, 32'd8);
        checkOutput("t3_no_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("t3_head", tdata, 32'hFFFF_F811);
        rxStart = rxCount;
        drainFifo();
        checkOutput("t3_rx_count", 32'(rxCount - rxStart), 32'd8);
        checkOutput("t3_new_last", lastRxData, 32'hFFFF_F899);

        // Random backpressure, strobe every third cycle.
        rxStart = rxCount;
        for (int c = 0; c < 3000; c++) begin
            rdy = 1'($urandom_range(0, 1));
            if (expQ.size() >= DEPTH - 1) rdy = 1'b1;
            applyStimulus(c % 3 == 0, 12'($urandom_range(0, 4095)), rdy, 1'b0);
        end
        drainFifo();
        checkOutput("t4_rx_count", 32'(rxCount - rxStart), 32'd1000);
        checkOutput("t4_no_overflow", {31'd0, overflow}, 32'd0);

        // Reset while holding data.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 12'h200 + 12'(i), 1'b0, 1'b0);
        end
        checkOutput("t5_level5", {28'd0, fifoLevel}, 32'd5);
        checkOutput("t5_tvalid_pre", {31'd0, tvalid}, 32'd1);
        rst = 1'b1;
        #2;
        checkOutput("t5_tvalid_async", {31'd0, tvalid}, 32'd0);
        checkOutput("t5_level_async", {28'd0, fifoLevel}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 12'h123, 1'b1, 1'b0);
        checkOutput("t5_first_after", tdata, 32'hFFFF_F923);
        drainFifo();

`ifdef AXIS_SRC_DROP_CNT_EN
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 12'h300 + 12'(i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 12'h3F0, 1'b0, 1'b0);
        end
        checkOutput("t6_drop_cnt3", {16'd0, dropCnt}, 32'd3);
        applyStimulus(1'b1, 12'h3F1, 1'b0, 1'b1);
        checkOutput("t6_drop_cnt_clr", {16'd0, dropCnt}, 32'd1);
        checkOutput("t6_overflow", {31'd0, overflow}, 32'd1);
        applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
        checkOutput("t6_cnt_zero", {16'd0, dropCnt}, 32'd0);
        drainFifo();
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
